// File: rtl/mac_rx_frame_filter.sv
// mac_rx_frame_filter: store-and-forward MAC RX with CRC-32, length and DA filtering.
// Define MAC_RX_STAT_EN to add saturating per-frame outcome counters.
module mac_rx_frame_filter #(
  parameter logic [47:0] LOCAL_MAC      = 48'hABCD_1234_5678,
  parameter int          BUF_ADDR_W     = 11,
  parameter int          FRM_FIFO_DEPTH = 8,
  parameter int          MIN_FRAME      = 64,
  parameter int          MAX_FRAME      = 1518,
  parameter bit          ACCEPT_MCAST   = 1'b0,
  parameter bit          PROMISC        = 1'b0
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [7:0]  mac_rphy_data_in,
  input  logic        mac_rphy_valid_in,
  input  logic        mac_rphy_err_in,
  output logic [7:0]  mac_tnet_data_out,
  output logic        mac_tnet_valid_out,
  input  logic        mac_tnet_ready_in,
  output logic        mac_tnet_last_out,
  output logic [15:0] mac_tnet_type_out
`ifdef MAC_RX_STAT_EN
  ,
  output logic [31:0] stat_good_out,
  output logic [31:0] stat_crc_err_out,
  output logic [31:0] stat_len_err_out,
  output logic [31:0] stat_filt_drop_out,
  output logic [31:0] stat_ovf_drop_out
`endif
);
  localparam int AW = BUF_ADDR_W;
  localparam int PW = AW + 1;
  localparam int FW = $clog2(FRM_FIFO_DEPTH);
  localparam int CW = $clog2(MAX_FRAME + 2);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, rem_q;
  logic [31:0]     crc_q;
  logic [47:0]     da_q;
  logic [15:0]     et_q;
  logic            err_q;
  logic [7:0]      mem [2**AW];
  logic [7:0]      ram_q;
  logic [CW-1:0]   ff_len_q  [FRM_FIFO_DEPTH];
  logic [15:0]     ff_type_q [FRM_FIFO_DEPTH];
  logic [FW:0]     ff_wp_q, ff_rp_q;
  logic            tx_act_q, inf_q, inf_last_q, s_vld_q, s_last_q, o_vld_q, o_last_q;
  logic [15:0]     inf_type_q, s_type_q, o_type_q;
  logic [7:0]      s_data_q, o_data_q;

  logic buf_full, ff_full, ff_empty, sfd, over, d_byte, frame_end;
  logic da_ok, len_ok, crc_ok, wr_en, commit, rewind;

  assign buf_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ff_full   = (ff_wp_q[FW] != ff_rp_q[FW]) && (ff_wp_q[FW-1:0] == ff_rp_q[FW-1:0]);
  assign ff_empty  = ff_wp_q == ff_rp_q;
  assign sfd       = state_q == PREAMBLE && mac_rphy_valid_in && mac_rphy_data_in == 8'hD5 && !ff_full;
  assign over      = cnt_q == CW'(MAX_FRAME);
  assign d_byte    = state_q == DATA && mac_rphy_valid_in;
  assign frame_end = state_q == DATA && !mac_rphy_valid_in;
  assign da_ok     = PROMISC || da_q == LOCAL_MAC || &da_q || (ACCEPT_MCAST && da_q[40]);
  assign len_ok    = cnt_q >= CW'(MIN_FRAME);
  assign crc_ok    = crc_q == 32'hDEBB_20E3 && !err_q;

  always_ff @(posedge logic_clk or negedge logic_rst_n)
    if (!logic_rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = !mac_rphy_valid_in ? IDLE : mac_rphy_data_in == 8'h55 ? PREAMBLE : DROP;
      PREAMBLE: state_d = !mac_rphy_valid_in ? IDLE : mac_rphy_data_in == 8'h55 ? PREAMBLE : sfd ? DATA : DROP;
      DATA:     state_d = !mac_rphy_valid_in ? IDLE : wr_en ? DATA : DROP;
      default:  state_d = mac_rphy_valid_in ? DROP : IDLE;
    endcase
  end

  always_comb begin
    wr_en    = d_byte && !over && !buf_full;
    commit   = frame_end && len_ok && crc_ok && da_ok;
    rewind   = state_q == DATA && !wr_en && !commit;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : rewind ? commit_ptr_q : wr_ptr_q;
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n)
    if (!logic_rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
      crc_q        <= '1;
      da_q         <= '0;
      et_q         <= '0;
      err_q        <= 1'b0;
      ff_wp_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (sfd) begin
        cnt_q <= '0;
        crc_q <= '1;
        err_q <= 1'b0;
      end else if (wr_en) begin
        cnt_q <= cnt_q + 1'b1;
        crc_q <= crc8(crc_q, mac_rphy_data_in);
        if (cnt_q < CW'(6)) da_q <= {da_q[39:0], mac_rphy_data_in};
        if (cnt_q == CW'(12)) et_q[15:8] <= mac_rphy_data_in;
        if (cnt_q == CW'(13)) et_q[7:0] <= mac_rphy_data_in;
        if (mac_rphy_err_in) err_q <= 1'b1;
      end
      if (commit) begin
        commit_ptr_q <= wr_ptr_q;
        ff_wp_q      <= ff_wp_q + 1'b1;
      end
    end

  always_ff @(posedge logic_clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= mac_rphy_data_in;
    ram_q <= mem[rd_ptr_q[AW-1:0]];
    if (commit) begin
      ff_len_q[ff_wp_q[FW-1:0]]  <= cnt_q - CW'(4);
      ff_type_q[ff_wp_q[FW-1:0]] <= et_q;
    end
  end

  // The head descriptor stays queued until its last byte is issued, so it counts toward FIFO fullness
  logic [CW-1:0] cur_rem;
  logic [15:0]   head_type;
  logic          out_free, can_issue, issue, is_last;

  always_comb begin
    cur_rem   = tx_act_q ? rem_q : ff_len_q[ff_rp_q[FW-1:0]];
    head_type = ff_type_q[ff_rp_q[FW-1:0]];
    out_free  = !o_vld_q || mac_tnet_ready_in;
    can_issue = !s_vld_q && !(inf_q && !out_free);
    issue     = can_issue && !ff_empty;
    is_last   = cur_rem == CW'(1);
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n)
    if (!logic_rst_n) begin
      rd_ptr_q   <= '0;
      ff_rp_q    <= '0;
      rem_q      <= '0;
      tx_act_q   <= 1'b0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      inf_type_q <= '0;
      s_vld_q    <= 1'b0;
      s_last_q   <= 1'b0;
      s_type_q   <= '0;
      s_data_q   <= '0;
      o_vld_q    <= 1'b0;
      o_last_q   <= 1'b0;
      o_type_q   <= '0;
      o_data_q   <= '0;
    end else begin
      if (issue) begin
        rem_q    <= cur_rem - 1'b1;
        tx_act_q <= !is_last;
        rd_ptr_q <= rd_ptr_q + (is_last ? PW'(5) : PW'(1));
        if (is_last) ff_rp_q <= ff_rp_q + 1'b1;
      end
      inf_q      <= issue;
      inf_last_q <= is_last;
      inf_type_q <= head_type;
      if (inf_q && (!out_free || s_vld_q)) begin
        s_data_q <= ram_q;
        s_last_q <= inf_last_q;
        s_type_q <= inf_type_q;
      end
      s_vld_q <= out_free ? s_vld_q && inf_q : s_vld_q || inf_q;
      if (out_free) begin
        o_vld_q <= s_vld_q || inf_q;
        if (s_vld_q || inf_q) begin
          o_data_q <= s_vld_q ? s_data_q : ram_q;
          o_last_q <= s_vld_q ? s_last_q : inf_last_q;
          o_type_q <= s_vld_q ? s_type_q : inf_type_q;
        end
      end
    end

  assign mac_tnet_data_out  = o_data_q;
  assign mac_tnet_valid_out = o_vld_q;
  assign mac_tnet_last_out  = o_last_q;
  assign mac_tnet_type_out  = o_type_q;

`ifdef MAC_RX_STAT_EN
  function automatic logic [31:0] sat(input logic [31:0] c, input logic e);
    return c + 32'(e && c != '1);
  endfunction

  logic ev_ovf, ev_len, ev_crc, ev_filt;
  logic [31:0] good_q, crc_err_q, len_err_q, filt_q, ovf_q;

  always_comb begin
    ev_ovf  = (state_q == PREAMBLE && mac_rphy_valid_in && mac_rphy_data_in == 8'hD5 && ff_full) || (d_byte && buf_full);
    ev_len  = (d_byte && over && !buf_full) || (frame_end && !len_ok);
    ev_crc  = frame_end && len_ok && !crc_ok;
    ev_filt = frame_end && len_ok && crc_ok && !da_ok;
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n)
    if (!logic_rst_n) begin
      good_q    <= '0;
      crc_err_q <= '0;
      len_err_q <= '0;
      filt_q    <= '0;
      ovf_q     <= '0;
    end else begin
      good_q    <= sat(good_q, commit);
      crc_err_q <= sat(crc_err_q, ev_crc);
      len_err_q <= sat(len_err_q, ev_len);
      filt_q    <= sat(filt_q, ev_filt);
      ovf_q     <= sat(ovf_q, ev_ovf);
    end

  assign stat_good_out      = good_q;
  assign stat_crc_err_out   = crc_err_q;
  assign stat_len_err_out   = len_err_q;
  assign stat_filt_drop_out = filt_q;
  assign stat_ovf_drop_out  = ovf_q;
`endif
endmodule

// File: tb/tb_mac_rx_frame_filter.sv
// tb_mac_rx_frame_filter: directed frames with bench-built FCS, checked against hand-derived output streams.
module tb_mac_rx_frame_filter;
  localparam logic [47:0] LOCAL = 48'hABCD_1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic [15:0] tx_type;
`ifdef MAC_RX_STAT_EN
  logic [31:0] st_good, st_crc, st_len, st_filt, st_ovf;
`endif

  always #5 clk = ~clk;

  mac_rx_frame_filter dut (
    .logic_clk(clk),
    .logic_rst_n(rst_n),
    .mac_rphy_data_in(rx_data),
    .mac_rphy_valid_in(rx_valid),
    .mac_rphy_err_in(rx_err),
    .mac_tnet_data_out(tx_data),
    .mac_tnet_valid_out(tx_valid),
    .mac_tnet_ready_in(tx_ready),
    .mac_tnet_last_out(tx_last),
    .mac_tnet_type_out(tx_type)
`ifdef MAC_RX_STAT_EN
    ,
    .stat_good_out(st_good),
    .stat_crc_err_out(st_crc),
    .stat_len_err_out(st_len),
    .stat_filt_drop_out(st_filt),
    .stat_ovf_drop_out(st_ovf)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  fr[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [15:0] rx_type[$];
  int          rx_lens[$];
  int          cur_len = 0;

  always @(negedge clk)
    if (!rst_n) cur_len = 0;
    else if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      cur_len++;
      if (tx_last) begin
        rx_lens.push_back(cur_len);
        rx_type.push_back(tx_type);
        cur_len = 0;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] et, input int total, input logic [7:0] seed);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(da[47-8*i -: 8]);
    fr.push_back(8'h02);
    for (int i = 0; i < 4; i++) fr.push_back(8'h00);
    fr.push_back(seed);
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    for (int i = 14; i < total - 4; i++) fr.push_back(seed + 8'(i));
    c = '1;
    foreach (fr[i]) begin
      c = c ^ {24'd0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  task automatic expect_frame();
    for (int i = 0; i < fr.size() - 4; i++) exp_q.push_back(fr[i]);
  endtask

  task automatic drive(input logic [7:0] d, input logic e);
    @(posedge clk);
    #1;
    rx_data = d;
    rx_valid = 1'b1;
    rx_err = e;
  endtask

  task automatic send(input int err_at);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    foreach (fr[i]) drive(fr[i], i == err_at);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data = '0;
      rx_err = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    rx_q.delete();
    exp_q.delete();
    rx_lens.delete();
    rx_type.delete();
  endtask

  task automatic compare(input string tag, input int nfr);
    int mism;
    mism = 0;
    chk({tag, "_bytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) mism++;
    chk({tag, "_data"}, mism, 0);
    chk({tag, "_frames"}, rx_lens.size(), nfr);
    flush();
  endtask

  initial begin
    int mism;
    #2 rst_n = 1'b0;
    settle(3);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_type", tx_type, 0);
    rst_n = 1'b1;
    settle(2);

    build(LOCAL, 16'h0800, 64, 8'h01);
    expect_frame();
    send(-1);
    settle(80);
    chk("good_type", rx_type.size() > 0 ? 32'(rx_type[0]) : 32'hDEAD, 16'h0800);
    chk("good_last_at", rx_lens.size() > 0 ? rx_lens[0] : -1, 60);
    compare("good", 1);

    build(LOCAL, 16'h0800, 64, 8'h02);
    send(30);
    settle(80);
    chk("err_drop", rx_q.size(), 0);
    build(LOCAL, 16'h0806, 64, 8'h03);
    expect_frame();
    send(-1);
    settle(80);
    chk("after_err_type", rx_type.size() > 0 ? 32'(rx_type[0]) : 32'hDEAD, 16'h0806);
    compare("after_err", 1);

    build(48'h1122_3344_5566, 16'h0800, 64, 8'h04);
    send(-1);
    build(48'hFFFF_FFFF_FFFF, 16'h0800, 70, 8'h05);
    expect_frame();
    send(-1);
    build(48'h0100_5E00_0001, 16'h0800, 64, 8'h06);
    send(-1);
    settle(80);
    compare("filter", 1);

    build(LOCAL, 16'h0800, 40, 8'h07);
    send(-1);
    build(LOCAL, 16'h0800, 1600, 8'h08);
    send(-1);
    build(LOCAL, 16'h86DD, 100, 8'h09);
    expect_frame();
    send(-1);
    settle(150);
    compare("len", 1);

    build(LOCAL, 16'h0800, 64, 8'h0A);
    fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    send(-1);
    settle(80);
    compare("crc", 0);

    tx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      build(LOCAL, 16'h8800 + 16'(k), 64, 8'h10 + 8'(k));
      if (k < 8) expect_frame();
      send(-1);
    end
    settle(10);
    chk("hold_valid", tx_valid, 1);
    chk("hold_data", tx_data, 8'hAB);
    chk("hold_type", tx_type, 16'h8800);
    settle(7);
    chk("hold_data2", tx_data, 8'hAB);
    chk("hold_last", tx_last, 0);
    tx_ready = 1'b1;
    settle(600);
    mism = 0;
    for (int k = 0; k < rx_type.size(); k++) if (rx_type[k] !== 16'h8800 + 16'(k)) mism++;
    chk("ovf_order", mism, 0);
    compare("ovf", 8);

`ifdef MAC_RX_STAT_EN
    chk("stat_good", st_good, 12);
    chk("stat_crc", st_crc, 2);
    chk("stat_len", st_len, 2);
    chk("stat_filt", st_filt, 2);
    chk("stat_ovf", st_ovf, 1);
`endif

    build(LOCAL, 16'h0800, 400, 8'h20);
    send(-1);
    for (int i = 0; i < 200 && rx_q.size() < 20; i++) @(posedge clk);
    chk("rst_mid_started", rx_q.size() >= 20, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", tx_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    flush();
`ifdef MAC_RX_STAT_EN
    chk("stat_rst_good", st_good, 0);
`endif
    build(LOCAL, 16'h0800, 64, 8'h30);
    expect_frame();
    send(-1);
    settle(80);
    chk("post_rst_first", rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hDEAD, 8'hAB);
    compare("post_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
